checkout_cashier: RTL and testbench

- Payment stage directly downstream of the ordering machine.
- Latches the confirmed order total, accepts 5/10/50 coins until the total is covered, then dispenses change one coin per cycle using greedy largest-coin-first.
- Supports cancel, which refunds everything inserted so far.
- Reports completion to the display/ticket logic with a one-cycle pulse.

---
 rtl/cashier_pkg.sv | 12 +
 rtl/checkout_cashier_if.sv | 36 +++
 rtl/change_dispenser.sv | 65 ++++++
 rtl/checkout_cashier.sv | 147 ++++++++++++++
 tb/tb_checkout_cashier.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cashier_pkg.sv
// Shared types and coin constants for the checkout cashier payment stage.
package cashier_pkg;

   localparam int PRICE_W = 8;
   localparam int AMT_W   = 9;
   localparam int COIN_S  = 5;
   localparam int COIN_M  = 10;
   localparam int COIN_L  = 50;

   typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, DONE} state_e;

endpackage

// File: rtl/checkout_cashier_if.sv
// Ordering-machine / coin-mechanism / display bundle around the cashier.
interface checkout_cashier_if #(
   parameter int PRICE_W = 8,
   parameter int AMT_W   = 9
);

   logic               order_valid;
   logic [PRICE_W-1:0] order_total;
   logic               coin_s;
   logic               coin_m;
   logic               coin_l;
   logic               btn_cancel;
   logic               busy;
   logic [PRICE_W-1:0] amount_due;
   logic [AMT_W-1:0]   amount_paid;
   logic               chg_s;
   logic               chg_m;
   logic               chg_l;
   logic               coin_reject;
   logic               order_reject;
   logic               sale_done;
   logic               refund_done;

   modport master (
      output order_valid, order_total, coin_s, coin_m, coin_l, btn_cancel,
      input  busy, amount_due, amount_paid, chg_s, chg_m, chg_l,
             coin_reject, order_reject, sale_done, refund_done
   );

   modport slave (
      input  order_valid, order_total, coin_s, coin_m, coin_l, btn_cancel,
      output busy, amount_due, amount_paid, chg_s, chg_m, chg_l,
             coin_reject, order_reject, sale_done, refund_done
   );

endinterface

// File: rtl/change_dispenser.sv
// Holds a change/refund balance and pays it out one coin per cycle, largest first.
module change_dispenser #(
   parameter int AMT_W  = cashier_pkg::AMT_W,
   parameter int COIN_S = cashier_pkg::COIN_S,
   parameter int COIN_M = cashier_pkg::COIN_M,
   parameter int COIN_L = cashier_pkg::COIN_L
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [AMT_W-1:0] load_val,
   input  logic             run,
   output logic             chg_s,
   output logic             chg_m,
   output logic             chg_l,
   output logic             empty
);

   logic [AMT_W-1:0] change_q, change_d;
   logic             chg_s_q, chg_s_d;
   logic             chg_m_q, chg_m_d;
   logic             chg_l_q, chg_l_d;

   always_comb begin
      change_d = change_q;
      chg_s_d  = 1'b0;
      chg_m_d  = 1'b0;
      chg_l_d  = 1'b0;
      if (load) begin
         change_d = load_val;
      end else if (run && (change_q != '0)) begin
         if (change_q >= AMT_W'(COIN_L)) begin
            chg_l_d  = 1'b1;
            change_d = change_q - AMT_W'(COIN_L);
         end else if (change_q >= AMT_W'(COIN_M)) begin
            chg_m_d  = 1'b1;
            change_d = change_q - AMT_W'(COIN_M);
         end else begin
            // An odd residue below the small coin still gets one coin, then clamps to zero.
            chg_s_d  = 1'b1;
            change_d = (change_q >= AMT_W'(COIN_S)) ? change_q - AMT_W'(COIN_S) : '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         change_q <= '0;
         chg_s_q  <= 1'b0;
         chg_m_q  <= 1'b0;
         chg_l_q  <= 1'b0;
      end else begin
         change_q <= change_d;
         chg_s_q  <= chg_s_d;
         chg_m_q  <= chg_m_d;
         chg_l_q  <= chg_l_d;
      end
   end

   assign chg_s = chg_s_q;
   assign chg_m = chg_m_q;
   assign chg_l = chg_l_q;
   assign empty = (change_q == '0);

endmodule

// File: rtl/checkout_cashier.sv
// Payment stage: latches an order total, collects coins, pays change or refunds,
// then pulses sale_done/refund_done for one cycle. All outputs are registered.
module checkout_cashier #(
   parameter int PRICE_W = cashier_pkg::PRICE_W,
   parameter int AMT_W   = cashier_pkg::AMT_W,
   parameter int COIN_S  = cashier_pkg::COIN_S,
   parameter int COIN_M  = cashier_pkg::COIN_M,
   parameter int COIN_L  = cashier_pkg::COIN_L
) (
   input  logic             clk,
   input  logic             reset,
   checkout_cashier_if.slave bus
);

   cashier_pkg::state_e state_q, state_d;
   logic [PRICE_W-1:0]  amount_due_q, amount_due_d;
   logic [AMT_W-1:0]    amount_paid_q, amount_paid_d;
   logic                refund_q, refund_d;
   logic                busy_q, busy_d;
   logic                coin_reject_q, coin_reject_d;
   logic                order_reject_q, order_reject_d;
   logic                sale_done_q, sale_done_d;
   logic                refund_done_q, refund_done_d;

   logic                any_coin;
   logic [AMT_W-1:0]    sum;
   logic                disp_load;
   logic [AMT_W-1:0]    disp_val;
   logic                disp_run;
   logic                disp_empty;

   always_comb begin
      any_coin = bus.coin_s | bus.coin_m | bus.coin_l;
      sum = amount_paid_q
          + (bus.coin_s ? AMT_W'(COIN_S) : '0)
          + (bus.coin_m ? AMT_W'(COIN_M) : '0)
          + (bus.coin_l ? AMT_W'(COIN_L) : '0);

      state_d        = state_q;
      amount_due_d   = amount_due_q;
      amount_paid_d  = amount_paid_q;
      refund_d       = refund_q;
      coin_reject_d  = any_coin && (state_q != cashier_pkg::COLLECT);
      order_reject_d = bus.order_valid && (state_q != cashier_pkg::IDLE);
      sale_done_d    = 1'b0;
      refund_done_d  = 1'b0;
      disp_load      = 1'b0;
      disp_val       = '0;
      disp_run       = (state_q == cashier_pkg::DISPENSE);

      unique case (state_q)
         cashier_pkg::IDLE: begin
            if (bus.order_valid) begin
               if (bus.order_total != '0) begin
                  amount_due_d  = bus.order_total;
                  amount_paid_d = '0;
                  state_d       = cashier_pkg::COLLECT;
               end else begin
                  state_d = cashier_pkg::DONE;
               end
            end
         end
         cashier_pkg::COLLECT: begin
            if (bus.btn_cancel) begin
               // Cancel wins; coins in the same cycle go straight back out the reject chute.
               coin_reject_d = any_coin;
               disp_load     = 1'b1;
               disp_val      = amount_paid_q;
               refund_d      = 1'b1;
               state_d       = cashier_pkg::DISPENSE;
            end else if (sum >= AMT_W'(amount_due_q)) begin
               disp_load = 1'b1;
               disp_val  = sum - AMT_W'(amount_due_q);
               state_d   = cashier_pkg::DISPENSE;
            end else begin
               amount_paid_d = sum;
            end
         end
         cashier_pkg::DISPENSE: begin
            if (disp_empty) begin
               state_d = cashier_pkg::DONE;
            end
         end
         cashier_pkg::DONE: begin
            sale_done_d   = !refund_q;
            refund_done_d = refund_q;
            amount_paid_d = '0;
            amount_due_d  = '0;
            refund_d      = 1'b0;
            state_d       = cashier_pkg::IDLE;
         end
         default: state_d = cashier_pkg::IDLE;
      endcase

      busy_d = (state_d != cashier_pkg::IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= cashier_pkg::IDLE;
         amount_due_q   <= '0;
         amount_paid_q  <= '0;
         refund_q       <= 1'b0;
         busy_q         <= 1'b0;
         coin_reject_q  <= 1'b0;
         order_reject_q <= 1'b0;
         sale_done_q    <= 1'b0;
         refund_done_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         amount_due_q   <= amount_due_d;
         amount_paid_q  <= amount_paid_d;
         refund_q       <= refund_d;
         busy_q         <= busy_d;
         coin_reject_q  <= coin_reject_d;
         order_reject_q <= order_reject_d;
         sale_done_q    <= sale_done_d;
         refund_done_q  <= refund_done_d;
      end
   end

   change_dispenser #(
      .AMT_W  (AMT_W),
      .COIN_S (COIN_S),
      .COIN_M (COIN_M),
      .COIN_L (COIN_L)
   ) u_dispenser (
      .clk      (clk),
      .reset    (reset),
      .load     (disp_load),
      .load_val (disp_val),
      .run      (disp_run),
      .chg_s    (bus.chg_s),
      .chg_m    (bus.chg_m),
      .chg_l    (bus.chg_l),
      .empty    (disp_empty)
   );

   assign bus.busy         = busy_q;
   assign bus.amount_due   = amount_due_q;
   assign bus.amount_paid  = amount_paid_q;
   assign bus.coin_reject  = coin_reject_q;
   assign bus.order_reject = order_reject_q;
   assign bus.sale_done    = sale_done_q;
   assign bus.refund_done  = refund_done_q;

endmodule

// File: tb/tb_checkout_cashier.sv
// Directed scenarios for checkout_cashier with hand-computed per-cycle output patterns.
module tb_checkout_cashier;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   // Observation vector bits: {busy, chg_l, chg_m, chg_s, coin_reject, order_reject, sale_done, refund_done}
   localparam logic [7:0] B  = 8'h80;
   localparam logic [7:0] L  = 8'h40;
   localparam logic [7:0] M  = 8'h20;
   localparam logic [7:0] S  = 8'h10;
   localparam logic [7:0] CR = 8'h08;
   localparam logic [7:0] OR = 8'h04;
   localparam logic [7:0] SD = 8'h02;
   localparam logic [7:0] RD = 8'h01;
   localparam logic [7:0] Z  = 8'h00;

   checkout_cashier_if #(.PRICE_W(8), .AMT_W(9)) bus ();

   checkout_cashier dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] obs();
      return {bus.busy, bus.chg_l, bus.chg_m, bus.chg_s,
              bus.coin_reject, bus.order_reject, bus.sale_done, bus.refund_done};
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.order_valid = 1'b0;
      bus.order_total = 8'd0;
      bus.coin_s      = 1'b0;
      bus.coin_m      = 1'b0;
      bus.coin_l      = 1'b0;
      bus.btn_cancel  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle_inputs();
      cycle();
      cycle();
      checks++;
      if (obs() !== Z) begin
         errors++; $display("FAIL reset_outs: got %b want %b", obs(), Z);
      end
      checks++;
      if (bus.amount_due !== 8'd0 || bus.amount_paid !== 9'd0) begin
         errors++; $display("FAIL reset_amounts: got due=%0d paid=%0d want 0/0", bus.amount_due, bus.amount_paid);
      end
      reset = 1'b1;
      cycle();
   endtask

   // 70 paid with two 50s: change 30 as three medium coins.
   task automatic test_change_mmm();
      logic [7:0] want [6];
      want = '{B, B|M, B|M, B|M, B, SD};
      bus.order_valid = 1'b1; bus.order_total = 8'd70;
      cycle(); idle_inputs();
      checks++;
      if (bus.amount_due !== 8'd70 || obs() !== B) begin
         errors++; $display("FAIL t1_latch: got due=%0d obs=%b want due=70 obs=%b", bus.amount_due, obs(), B);
      end
      bus.coin_l = 1'b1;
      cycle(); idle_inputs();
      checks++;
      if (bus.amount_paid !== 9'd50) begin
         errors++; $display("FAIL t1_paid50: got %0d want 50", bus.amount_paid);
      end
      bus.coin_l = 1'b1;
      cycle(); idle_inputs();
      for (int i = 0; i < 6; i++) begin
         if (i != 0) cycle();
         checks++;
         if (obs() !== want[i]) begin
            errors++; $display("FAIL t1_seq%0d: got %b want %b", i, obs(), want[i]);
         end
      end
      checks++;
      if (bus.amount_due !== 8'd0 || bus.amount_paid !== 9'd0) begin
         errors++; $display("FAIL t1_clear: got due=%0d paid=%0d want 0/0", bus.amount_due, bus.amount_paid);
      end
      cycle();
   endtask

   // 35 paid with one 50: change 15 as medium then small.
   task automatic test_change_ms();
      logic [7:0] want [5];
      want = '{B, B|M, B|S, B, SD};
      bus.order_valid = 1'b1; bus.order_total = 8'd35;
      cycle(); idle_inputs();
      bus.coin_l = 1'b1;
      cycle(); idle_inputs();
      for (int i = 0; i < 5; i++) begin
         if (i != 0) cycle();
         checks++;
         if (obs() !== want[i]) begin
            errors++; $display("FAIL t2_seq%0d: got %b want %b", i, obs(), want[i]);
         end
      end
      cycle();
   endtask

   // 170 order, 110 inserted, cancel with a coin in the same cycle: refund 50,50,10.
   task automatic test_cancel_refund();
      logic [7:0] want [7];
      want = '{B|CR, B|L, B|L, B|M, B, RD, Z};
      bus.order_valid = 1'b1; bus.order_total = 8'd170;
      cycle(); idle_inputs();
      bus.coin_l = 1'b1; cycle(); idle_inputs();
      bus.coin_l = 1'b1; cycle(); idle_inputs();
      bus.coin_m = 1'b1; cycle(); idle_inputs();
      checks++;
      if (bus.amount_paid !== 9'd110) begin
         errors++; $display("FAIL t3_paid110: got %0d want 110", bus.amount_paid);
      end
      bus.btn_cancel = 1'b1; bus.coin_s = 1'b1;
      cycle(); idle_inputs();
      for (int i = 0; i < 7; i++) begin
         if (i != 0) cycle();
         checks++;
         if (obs() !== want[i]) begin
            errors++; $display("FAIL t3_seq%0d: got %b want %b", i, obs(), want[i]);
         end
      end
   endtask

   // Three simultaneous coins pay 65 exactly: no change, sale_done two cycles later.
   task automatic test_exact_simultaneous();
      logic [7:0] want [4];
      want = '{B, B, SD, Z};
      bus.order_valid = 1'b1; bus.order_total = 8'd65;
      cycle(); idle_inputs();
      bus.coin_l = 1'b1; bus.coin_m = 1'b1; bus.coin_s = 1'b1;
      cycle(); idle_inputs();
      for (int i = 0; i < 4; i++) begin
         if (i != 0) cycle();
         checks++;
         if (obs() !== want[i]) begin
            errors++; $display("FAIL t4_seq%0d: got %b want %b", i, obs(), want[i]);
         end
      end
   endtask

   // Order and coin during DISPENSE are rejected without disturbing change; IDLE coin rejected.
   task automatic test_rejects();
      logic [7:0] want [6];
      want = '{B, B|M, B|M|OR|CR, B|M, B, SD};
      bus.order_valid = 1'b1; bus.order_total = 8'd20;
      cycle(); idle_inputs();
      bus.coin_l = 1'b1;
      cycle(); idle_inputs();
      for (int i = 0; i < 6; i++) begin
         if (i != 0) begin
            if (i == 2) begin
               bus.order_valid = 1'b1; bus.order_total = 8'd40; bus.coin_s = 1'b1;
            end
            cycle(); idle_inputs();
         end
         checks++;
         if (obs() !== want[i]) begin
            errors++; $display("FAIL t5_seq%0d: got %b want %b", i, obs(), want[i]);
         end
         if (i == 2) begin
            checks++;
            if (bus.amount_due !== 8'd20) begin
               errors++; $display("FAIL t5_due_kept: got %0d want 20", bus.amount_due);
            end
         end
      end
      bus.coin_m = 1'b1; bus.btn_cancel = 1'b1;
      cycle(); idle_inputs();
      checks++;
      if (obs() !== CR) begin
         errors++; $display("FAIL t5_idle_coin: got %b want %b", obs(), CR);
      end
      cycle();
      checks++;
      if (obs() !== Z) begin
         errors++; $display("FAIL t5_idle_after: got %b want %b", obs(), Z);
      end
   endtask

   // Reset mid-dispense with 40 change outstanding, then a zero-total order.
   task automatic test_reset_mid_dispense();
      bus.order_valid = 1'b1; bus.order_total = 8'd60;
      cycle(); idle_inputs();
      bus.coin_l = 1'b1; cycle(); idle_inputs();
      bus.coin_l = 1'b1; cycle(); idle_inputs();
      checks++;
      if (obs() !== B) begin
         errors++; $display("FAIL t6_in_dispense: got %b want %b", obs(), B);
      end
      reset = 1'b0;
      cycle();
      checks++;
      if (obs() !== Z || bus.amount_due !== 8'd0 || bus.amount_paid !== 9'd0) begin
         errors++; $display("FAIL t6_reset: got obs=%b due=%0d paid=%0d want %b 0 0", obs(), bus.amount_due, bus.amount_paid, Z);
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++;
         if (obs() !== Z) begin
            errors++; $display("FAIL t6_quiet%0d: got %b want %b", i, obs(), Z);
         end
      end
      bus.order_valid = 1'b1; bus.order_total = 8'd0;
      cycle(); idle_inputs();
      checks++;
      if (obs() !== B) begin
         errors++; $display("FAIL t6_zero_done_state: got %b want %b", obs(), B);
      end
      cycle();
      checks++;
      if (obs() !== SD) begin
         errors++; $display("FAIL t6_zero_sale_done: got %b want %b", obs(), SD);
      end
      cycle();
      checks++;
      if (obs() !== Z) begin
         errors++; $display("FAIL t6_zero_idle: got %b want %b", obs(), Z);
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_change_mmm();
      test_change_ms();
      test_cancel_refund();
      test_exact_simultaneous();
      test_rejects();
      test_reset_mid_dispense();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
